// File: rtl/step_sequencer.sv
// Microcode T-state sequencer: walks step 0..LAST_STEP per instruction with stall,
// early end (clr), HALT/resume, a one-hot step bus and a saturating retire counter.
module step_sequencer #(
  parameter int STEP_W    = 3,
  parameter int LAST_STEP = 7,
  parameter int CNT_W     = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 en,
  input  logic                 clr,
  input  logic                 halt_req,
  input  logic                 resume,
  output logic [STEP_W-1:0]    step,
  output logic [2**STEP_W-1:0] step_onehot,
  output logic                 instr_done,
  output logic                 halted,
  output logic [CNT_W-1:0]     retired
);

  localparam logic [STEP_W-1:0] LAST    = STEP_W'(LAST_STEP);
  localparam logic [CNT_W-1:0]  CNT_MAX = {CNT_W{1'b1}};

  if (LAST_STEP <= 0 || LAST_STEP >= 2**STEP_W) begin : g_bad_last_step
    $error("step_sequencer: LAST_STEP must satisfy 0 < LAST_STEP < 2**STEP_W");
  end

  typedef enum logic {
    RUN    = 1'b0,
    HALTED = 1'b1
  } state_t;

  state_t              state_r;
  state_t              next_state_s;
  logic [STEP_W-1:0]   step_next_s;
  logic                done_next_s;
  logic                retire_s;

  // Next-state, next-step and retire decode; clr outranks halt_req, which outranks stall.
  always_comb begin
    next_state_s = state_r;
    step_next_s  = step;
    done_next_s  = 1'b0;
    retire_s     = 1'b0;
    case (state_r)
      RUN: begin
        if (clr) begin
          step_next_s = {STEP_W{1'b0}};
          done_next_s = 1'b1;
          retire_s    = 1'b1;
        end else if (halt_req) begin
          next_state_s = HALTED;
          step_next_s  = {STEP_W{1'b0}};
        end else if (!en) begin
          step_next_s = step;
        end else if (step == LAST) begin
          step_next_s = {STEP_W{1'b0}};
          done_next_s = 1'b1;
          retire_s    = 1'b1;
        end else begin
          step_next_s = step + STEP_W'(1);
        end
      end
      HALTED: begin
        step_next_s = {STEP_W{1'b0}};
        if (resume) begin
          next_state_s = RUN;
        end else begin
          next_state_s = HALTED;
        end
      end
      default: begin
        next_state_s = RUN;
        step_next_s  = {STEP_W{1'b0}};
      end
    endcase
  end

  // State, step, retire pulse and saturating retire counter registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r    <= RUN;
      step       <= {STEP_W{1'b0}};
      instr_done <= 1'b0;
      retired    <= {CNT_W{1'b0}};
    end else begin
      state_r    <= next_state_s;
      step       <= step_next_s;
      instr_done <= done_next_s;
      if (retire_s && (retired != CNT_MAX)) begin
        retired <= retired + CNT_W'(1);
      end else begin
        retired <= retired;
      end
    end
  end

  assign halted = (state_r == HALTED);

  // One-hot decode of the registered step; blanked while halted.
  always_comb begin
    step_onehot = {(2**STEP_W){1'b0}};
    if (state_r == RUN) begin
      step_onehot[step] = 1'b1;
    end else begin
      step_onehot = {(2**STEP_W){1'b0}};
    end
  end

endmodule

// File: tb/tb_step_sequencer.sv
// Directed self-checking bench for step_sequencer: default, LAST_STEP=4 and CNT_W=2
// instances share one stimulus stream; expectations are hand-computed.
module tb_step_sequencer;

  logic clk = 1'b0;
  logic reset, en, clr, halt_req, resume;

  logic [2:0]  step_a, step_b, step_c;
  logic [7:0]  oh_a, oh_b, oh_c;
  logic        done_a, done_b, done_c;
  logic        halt_a, halt_b, halt_c;
  logic [15:0] ret_a;
  logic [15:0] ret_b;
  logic [1:0]  ret_c;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  step_sequencer #(.STEP_W(3), .LAST_STEP(7), .CNT_W(16)) u_dut (
    .clk(clk), .reset(reset), .en(en), .clr(clr), .halt_req(halt_req), .resume(resume),
    .step(step_a), .step_onehot(oh_a), .instr_done(done_a), .halted(halt_a), .retired(ret_a));

  step_sequencer #(.STEP_W(3), .LAST_STEP(4), .CNT_W(16)) u_dut4 (
    .clk(clk), .reset(reset), .en(en), .clr(clr), .halt_req(halt_req), .resume(resume),
    .step(step_b), .step_onehot(oh_b), .instr_done(done_b), .halted(halt_b), .retired(ret_b));

  step_sequencer #(.STEP_W(3), .LAST_STEP(7), .CNT_W(2)) u_sat (
    .clk(clk), .reset(reset), .en(en), .clr(clr), .halt_req(halt_req), .resume(resume),
    .step(step_c), .step_onehot(oh_c), .instr_done(done_c), .halted(halt_c), .retired(ret_c));

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_main(input string tag, input int exp_step, input bit exp_done);
    check_val({tag, ".step"}, 32'(step_a), 32'(exp_step));
    check_val({tag, ".onehot"}, 32'(oh_a), 32'h1 << exp_step);
    check_val({tag, ".done"}, 32'(done_a), 32'(exp_done));
  endtask

  initial begin
    reset = 1'b1; en = 1'b0; clr = 1'b0; halt_req = 1'b0; resume = 1'b0;
    #2;
    check_main("reset", 0, 1'b0);
    check_val("reset.halted", 32'(halt_a), 32'd0);
    check_val("reset.retired", 32'(ret_a), 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // Test 1 / 2: free run, LAST_STEP=7 and LAST_STEP=4 side by side
    en = 1'b1;
    for (int i = 1; i <= 9; i++) begin
      tick();
      check_main("run7", i % 8, i == 8);
      check_val("run4.step", 32'(step_b), 32'(i % 5));
      check_val("run4.done", 32'(done_b), 32'(i == 5));
    end
    check_val("run7.retired", 32'(ret_a), 32'd1);
    check_val("run4.retired", 32'(ret_b), 32'd1);

    // Test 3: stall at step 3
    tick(); tick();
    check_main("pre_stall", 3, 1'b0);
    en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_main("stall", 3, 1'b0);
    end
    en = 1'b1;
    tick();
    check_main("unstall", 4, 1'b0);
    check_val("unstall.retired", 32'(ret_a), 32'd1);

    // Back-to-back clr keeps instr_done high
    clr = 1'b1;
    tick();
    check_main("clr1", 0, 1'b1);
    check_val("clr1.retired", 32'(ret_a), 32'd2);
    tick();
    check_main("clr2", 0, 1'b1);
    check_val("clr2.retired", 32'(ret_a), 32'd3);
    clr = 1'b0;
    tick();
    check_main("after_clr", 1, 1'b0);
    tick();

    // Test 4: clr beats en=0 and halt_req
    check_main("pre_prio", 2, 1'b0);
    clr = 1'b1; en = 1'b0; halt_req = 1'b1;
    tick();
    check_main("prio", 0, 1'b1);
    check_val("prio.retired", 32'(ret_a), 32'd4);
    check_val("prio.halted", 32'(halt_a), 32'd0);
    clr = 1'b0; halt_req = 1'b0; en = 1'b1;

    // Test 5: halt at step 5, ignore inputs, resume
    for (int i = 0; i < 5; i++) tick();
    check_main("pre_halt", 5, 1'b0);
    halt_req = 1'b1;
    tick();
    halt_req = 1'b0;
    check_val("halt.halted", 32'(halt_a), 32'd1);
    check_val("halt.step", 32'(step_a), 32'd0);
    check_val("halt.onehot", 32'(oh_a), 32'd0);
    check_val("halt.done", 32'(done_a), 32'd0);
    clr = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check_val("halted.step", 32'(step_a), 32'd0);
      check_val("halted.halted", 32'(halt_a), 32'd1);
      check_val("halted.done", 32'(done_a), 32'd0);
    end
    clr = 1'b0;
    check_val("halted.retired", 32'(ret_a), 32'd4);
    resume = 1'b1;
    tick();
    check_val("resume.halted", 32'(halt_a), 32'd0);
    check_main("resume", 0, 1'b0);
    resume = 1'b0;
    tick();
    check_main("post_resume", 1, 1'b0);
    resume = 1'b1;
    tick();
    resume = 1'b0;
    check_main("resume_in_run", 2, 1'b0);
    check_val("resume_in_run.halted", 32'(halt_a), 32'd0);

    // Test 6: async reset mid-cycle at step 6
    for (int i = 0; i < 4; i++) tick();
    check_main("pre_reset", 6, 1'b0);
    #2;
    reset = 1'b1;
    #1;
    check_main("async_reset", 0, 1'b0);
    check_val("async_reset.retired", 32'(ret_a), 32'd0);
    check_val("async_reset.halted", 32'(halt_a), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    en = 1'b0; clr = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      tick();
      check_val("sat.retired", 32'(ret_c), 32'(i > 3 ? 3 : i));
    end
    check_val("wide.retired", 32'(ret_a), 32'd5);
    clr = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
